// File: rtl/mult_block_buffer_if.sv
// rtl/mult_block_buffer_if.sv - operand, memory and readback signal bundle for mult_block_buffer
interface mult_block_buffer_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 6
);
    logic              EN_mult;
    logic [IN_W-1:0]   mult_input0;
    logic [IN_W-1:0]   mult_input1;
    logic              EN_flush;
    logic              EN_blockRead;
    logic [OUT_W-1:0]  readMem_val;
    logic              RDY_mult;
    logic              EN_writeMem;
    logic [ADDR_W-1:0] writeMem_addr;
    logic [OUT_W-1:0]  writeMem_val;
    logic              EN_readMem;
    logic [ADDR_W-1:0] readMem_addr;
    logic              BLOCK_full;
    logic [ADDR_W:0]   blk_len;
    logic              VALID_memVal;
    logic              LAST_memVal;
    logic [OUT_W-1:0]  memVal_data;

    modport slave (
        input  EN_mult, mult_input0, mult_input1, EN_flush, EN_blockRead, readMem_val,
        output RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
               readMem_addr, BLOCK_full, blk_len, VALID_memVal, LAST_memVal, memVal_data
    );

    modport master (
        output EN_mult, mult_input0, mult_input1, EN_flush, EN_blockRead, readMem_val,
        input  RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
               readMem_addr, BLOCK_full, blk_len, VALID_memVal, LAST_memVal, memVal_data
    );
endinterface

// File: rtl/mult_block_buffer.sv
// rtl/mult_block_buffer.sv - 2-stage multiplier filling an external memory block, read back on request
module mult_block_buffer #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int SIGNED = 0
) (
    input logic               CLK,
    input logic               RST_N,
    mult_block_buffer_if.slave bus
);
    typedef enum logic [1:0] {S_WRITE, S_DRAIN, S_FULL, S_READ} state_t;

    localparam int CNT_W = ADDR_W + 2;

    state_t              state_q, state_d;
    logic                s1_vld_q, s1_vld_d;
    logic [IN_W-1:0]     a_q, a_d, b_q, b_d;
    logic                s2_vld_q, s2_vld_d;
    logic [OUT_W-1:0]    prod_q, prod_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_last_q, rd_last_d;

    logic [CNT_W-1:0]    occupancy;
    logic                rdy;
    logic                accept;
    logic                rd_last;
    logic [2*IN_W-1:0]   prod_raw;
    logic [2*IN_W-1:0]   op_a_ext, op_b_ext;
    logic [OUT_W-1:0]    prod_ext;

    // Words written plus words still in the pipeline; gating on this keeps every accepted product inside the block.
    assign occupancy = CNT_W'(wr_cnt_q) + CNT_W'(s1_vld_q) + CNT_W'(s2_vld_q);
    assign rdy       = RST_N && (state_q == S_WRITE) && (occupancy < CNT_W'(DEPTH));
    assign accept    = bus.EN_mult && rdy;
    assign rd_last   = (state_q == S_READ) && (rd_cnt_q == wr_cnt_q - 1'b1);

    always_comb begin
        op_a_ext = {{IN_W{1'b0}}, a_q};
        op_b_ext = {{IN_W{1'b0}}, b_q};
        if (SIGNED != 0) begin
            op_a_ext = {{IN_W{a_q[IN_W-1]}}, a_q};
            op_b_ext = {{IN_W{b_q[IN_W-1]}}, b_q};
        end
        prod_raw = op_a_ext * op_b_ext;
        prod_ext = OUT_W'(prod_raw);
        if (SIGNED != 0) begin
            prod_ext = OUT_W'(signed'(prod_raw));
        end
    end

    always_comb begin
        state_d   = state_q;
        s1_vld_d  = accept;
        a_d       = a_q;
        b_d       = b_q;
        s2_vld_d  = s1_vld_q;
        prod_d    = prod_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        rd_vld_d  = (state_q == S_READ);
        rd_last_d = rd_last;

        if (accept) begin
            a_d = bus.mult_input0;
            b_d = bus.mult_input1;
        end
        if (s1_vld_q) begin
            prod_d = prod_ext;
        end
        if (s2_vld_q) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        case (state_q)
            S_WRITE: begin
                if (wr_cnt_d == (ADDR_W+1)'(DEPTH)) begin
                    state_d = S_FULL;
                end else if (bus.EN_flush && ((occupancy != '0) || accept)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last in-flight word may still be writing this edge; wr_cnt_d already counts it.
                if (!s1_vld_q) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.EN_blockRead) begin
                    state_d  = S_READ;
                    rd_cnt_d = '0;
                end
            end
            S_READ: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_last) begin
                    state_d  = S_WRITE;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                end
            end
            default: state_d = S_WRITE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_WRITE;
            s1_vld_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s2_vld_q  <= 1'b0;
            prod_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_vld_q  <= s1_vld_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s2_vld_q  <= s2_vld_d;
            prod_q    <= prod_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign bus.RDY_mult      = rdy;
    assign bus.EN_writeMem   = s2_vld_q;
    assign bus.writeMem_addr = wr_cnt_q[ADDR_W-1:0];
    assign bus.writeMem_val  = prod_q;
    assign bus.EN_readMem    = (state_q == S_READ);
    assign bus.readMem_addr  = rd_cnt_q[ADDR_W-1:0];
    assign bus.BLOCK_full    = (state_q == S_FULL);
    assign bus.blk_len       = ((state_q == S_FULL) || (state_q == S_READ)) ? wr_cnt_q : '0;
    assign bus.VALID_memVal  = rd_vld_q;
    assign bus.LAST_memVal   = rd_last_q;
    assign bus.memVal_data   = bus.readMem_val;
endmodule
